// File: rtl/lock_pkg.sv
// Shared types and timing constants for the digital lock datapath.
// The divider toggle count and the lockout length come from one tick period.
package lock_pkg;

  typedef enum logic {
    ARMED   = 1'b0,
    LOCKOUT = 1'b1
  } lock_state_e;

  localparam int CLK_HZ          = 50_000_000;
  localparam int TICK_PERIOD_MS  = 200;
  localparam int LOCKOUT_MS      = 10_000;

  // Half-period count for the slow divider; it toggles its output at this count.
  localparam int DIV_TOGGLE_COUNT = (CLK_HZ / 1000) * TICK_PERIOD_MS / 2;

  localparam int DEFAULT_MAX_ATTEMPTS  = 3;
  localparam int DEFAULT_LOCKOUT_TICKS = LOCKOUT_MS / TICK_PERIOD_MS;

endpackage

// File: rtl/edge_tick.sv
// Two-flop synchronizer plus history flop; emits a one-cycle tick per rising
// edge of an asynchronous or slow level input.
module edge_tick (
  input  logic clk_in,
  input  logic rst,
  input  logic level_in,
  output logic tick_out
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = level_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign tick_out = s2_q & ~s3_q;

endmodule

// File: rtl/lockout_timer.sv
// Failed-attempt counter with timed lockout driven by the slow divider tick.
// Drives the lockout flag, remaining-time display count and status LED blink.
module lockout_timer
  import lock_pkg::*;
#(
  parameter int MAX_ATTEMPTS  = DEFAULT_MAX_ATTEMPTS,
  parameter int LOCKOUT_TICKS = DEFAULT_LOCKOUT_TICKS,
  parameter int ATT_W         = 2,
  parameter int CNT_W         = 6
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             fail_pulse,
  input  logic             success_pulse,
  output logic             locked_out,
  output logic [ATT_W-1:0] attempts,
  output logic [CNT_W-1:0] ticks_left,
  output logic             blink,
  output logic             lockout_done
);

  localparam logic [ATT_W-1:0] MAX_ATT_C   = ATT_W'(MAX_ATTEMPTS);
  localparam logic [ATT_W:0]   ATT_LIMIT   = (ATT_W + 1)'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0] LOCK_TICK_C = CNT_W'(LOCKOUT_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > (2 ** ATT_W) - 1) begin : g_bad_max_attempts
    $error("lockout_timer: MAX_ATTEMPTS must be >= 1 and fit in ATT_W bits");
  end
  if (LOCKOUT_TICKS < 1 || LOCKOUT_TICKS > (2 ** CNT_W) - 1) begin : g_bad_lockout_ticks
    $error("lockout_timer: LOCKOUT_TICKS must be >= 1 and fit in CNT_W bits");
  end

  logic tick;

  edge_tick u_edge_tick (
    .clk_in   (clk_in),
    .rst      (rst),
    .level_in (slow_clk),
    .tick_out (tick)
  );

  lock_state_e      state_q, state_d;
  logic [ATT_W-1:0] attempts_q, attempts_d;
  logic [CNT_W-1:0] ticks_left_q, ticks_left_d;
  logic             locked_out_q, locked_out_d;
  logic             blink_q, blink_d;
  logic             lockout_done_q, lockout_done_d;
  logic [ATT_W:0]   att_inc;

  always_comb begin
    state_d        = state_q;
    attempts_d     = attempts_q;
    ticks_left_d   = ticks_left_q;
    locked_out_d   = locked_out_q;
    blink_d        = blink_q;
    lockout_done_d = 1'b0;
    att_inc        = {1'b0, attempts_q} + 1'b1;

    case (state_q)
      ARMED: begin
        // Success takes priority so a simultaneous fail cannot push toward lockout.
        if (success_pulse) begin
          attempts_d = '0;
        end else if (fail_pulse) begin
          if (att_inc >= ATT_LIMIT) begin
            state_d      = LOCKOUT;
            attempts_d   = MAX_ATT_C;
            ticks_left_d = LOCK_TICK_C;
            locked_out_d = 1'b1;
            blink_d      = 1'b0;
          end else begin
            attempts_d = att_inc[ATT_W-1:0];
          end
        end
      end
      LOCKOUT: begin
        // A zero count is treated as expiry so the counter can never wrap.
        if (tick) begin
          if (ticks_left_q > CNT_ONE) begin
            ticks_left_d = ticks_left_q - CNT_ONE;
            blink_d      = ~blink_q;
          end else begin
            state_d        = ARMED;
            ticks_left_d   = '0;
            attempts_d     = '0;
            locked_out_d   = 1'b0;
            blink_d        = 1'b0;
            lockout_done_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q        <= ARMED;
      attempts_q     <= '0;
      ticks_left_q   <= '0;
      locked_out_q   <= 1'b0;
      blink_q        <= 1'b0;
      lockout_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      attempts_q     <= attempts_d;
      ticks_left_q   <= ticks_left_d;
      locked_out_q   <= locked_out_d;
      blink_q        <= blink_d;
      lockout_done_q <= lockout_done_d;
    end
  end

  assign locked_out   = locked_out_q;
  assign attempts     = attempts_q;
  assign ticks_left   = ticks_left_q;
  assign blink        = blink_q;
  assign lockout_done = lockout_done_q;

endmodule

// File: tb/tb_lockout_timer.sv
// Directed bench for lockout_timer with MAX_ATTEMPTS=3, LOCKOUT_TICKS=4.
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_lockout_timer;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       slow_clk = 1'b0;
  logic       fail_pulse = 1'b0;
  logic       success_pulse = 1'b0;
  logic       locked_out;
  logic [1:0] attempts;
  logic [2:0] ticks_left;
  logic       blink;
  logic       lockout_done;

  int assertions = 0;
  int failures = 0;

  lockout_timer #(
    .MAX_ATTEMPTS  (3),
    .LOCKOUT_TICKS (4),
    .ATT_W         (2),
    .CNT_W         (3)
  ) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .slow_clk      (slow_clk),
    .fail_pulse    (fail_pulse),
    .success_pulse (success_pulse),
    .locked_out    (locked_out),
    .attempts      (attempts),
    .ticks_left    (ticks_left),
    .blink         (blink),
    .lockout_done  (lockout_done)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  // Pulses are held for the first cycle only; slow_clk keeps its level.
  task automatic applyStimulus(input logic f, input logic s, input logic sc, input int n);
    fail_pulse    = f;
    success_pulse = s;
    slow_clk      = sc;
    cycle();
    fail_pulse    = 1'b0;
    success_pulse = 1'b0;
    for (int i = 1; i < n; i++) cycle();
  endtask

  task automatic checkOutput(input string tag, input logic exp_l, input logic [1:0] exp_a,
                             input logic [2:0] exp_t, input logic exp_b, input logic exp_d);
    assertions++;
    assert (locked_out === exp_l) else begin
      failures++;
      $error("[TB] FAIL %s locked_out observed=%0b expected=%0b", tag, locked_out, exp_l);
    end
    assertions++;
    assert (attempts === exp_a) else begin
      failures++;
      $error("[TB] FAIL %s attempts observed=%0d expected=%0d", tag, attempts, exp_a);
    end
    assertions++;
    assert (ticks_left === exp_t) else begin
      failures++;
      $error("[TB] FAIL %s ticks_left observed=%0d expected=%0d", tag, ticks_left, exp_t);
    end
    assertions++;
    assert (blink === exp_b) else begin
      failures++;
      $error("[TB] FAIL %s blink observed=%0b expected=%0b", tag, blink, exp_b);
    end
    assertions++;
    assert (lockout_done === exp_d) else begin
      failures++;
      $error("[TB] FAIL %s lockout_done observed=%0b expected=%0b", tag, lockout_done, exp_d);
    end
  endtask

  // One full slow period while locked out: rising edge at the first driven cycle,
  // effect lands on the third edge, done drops one cycle later, falling edge is inert.
  task automatic slowTick(input string tag, input logic [2:0] pre_t, input logic pre_b,
                          input logic post_l, input logic [1:0] post_a, input logic [2:0] post_t,
                          input logic post_b, input logic post_d, input logic fail_at_tick);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    checkOutput({tag, "_pre"}, 1'b1, 2'd3, pre_t, pre_b, 1'b0);
    applyStimulus(fail_at_tick, 1'b0, 1'b1, 1);
    checkOutput({tag, "_post"}, post_l, post_a, post_t, post_b, post_d);
    applyStimulus(1'b0, 1'b0, 1'b1, 17);
    checkOutput({tag, "_hold"}, post_l, post_a, post_t, post_b, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    checkOutput({tag, "_fall"}, post_l, post_a, post_t, post_b, 1'b0);
  endtask

  initial begin
    $display("[TB] starting lockout_timer directed test");

    // Reset and idle with slow_clk toggling
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    checkOutput("reset", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++)
      applyStimulus(1'b0, 1'b0, (i >= 20 && i < 40), 1);
    checkOutput("idle_mid", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 50; i < 100; i++)
      applyStimulus(1'b0, 1'b0, (i >= 60 && i < 80), 1);
    checkOutput("idle_end", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);

    // Counting and clearing attempts
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("fail1", 1'b0, 2'd1, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("fail2", 1'b0, 2'd2, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("success", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("fail_after_success", 1'b0, 2'd1, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3);
    checkOutput("clear", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);

    // Lockout entry and full countdown
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("lk_pre", 1'b0, 2'd2, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("lk_enter", 1'b1, 2'd3, 3'd4, 1'b0, 1'b0);
    slowTick("t1", 3'd4, 1'b0, 1'b1, 2'd3, 3'd3, 1'b1, 1'b0, 1'b0);
    slowTick("t2", 3'd3, 1'b1, 1'b1, 2'd3, 3'd2, 1'b0, 1'b0, 1'b0);
    slowTick("t3", 3'd2, 1'b0, 1'b1, 2'd3, 3'd1, 1'b1, 1'b0, 1'b0);
    slowTick("t4", 3'd1, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Pulses ignored during lockout
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("lk2_enter", 1'b1, 2'd3, 3'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("lk2_fail", 1'b1, 2'd3, 3'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("lk2_success", 1'b1, 2'd3, 3'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("lk2_both", 1'b1, 2'd3, 3'd4, 1'b0, 1'b0);
    slowTick("lk2_t1", 3'd4, 1'b0, 1'b1, 2'd3, 3'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("lk2_both_t3", 1'b1, 2'd3, 3'd3, 1'b1, 1'b0);
    slowTick("lk2_t2", 3'd3, 1'b1, 1'b1, 2'd3, 3'd2, 1'b0, 1'b0, 1'b0);

    // Reset aborts lockout with no done pulse
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkOutput("abort", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 20);
    checkOutput("abort_high", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    checkOutput("abort_low", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("lk3_enter", 1'b1, 2'd3, 3'd4, 1'b0, 1'b0);

    // Fail coincident with the expiring tick
    slowTick("lk3_t1", 3'd4, 1'b0, 1'b1, 2'd3, 3'd3, 1'b1, 1'b0, 1'b0);
    slowTick("lk3_t2", 3'd3, 1'b1, 1'b1, 2'd3, 3'd2, 1'b0, 1'b0, 1'b0);
    slowTick("lk3_t3", 3'd2, 1'b0, 1'b1, 2'd3, 3'd1, 1'b1, 1'b0, 1'b0);
    slowTick("lk3_t4", 3'd1, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("rearm_fail", 1'b0, 2'd1, 3'd0, 1'b0, 1'b0);

    // Both pulses at attempts=2 clear without locking
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("armed_two", 1'b0, 2'd2, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("armed_both", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("final", 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/lockout_timer.md
Name: lockout_timer

Overview:
- Sits directly downstream of the slow clock divider in the digital lock.
- Consumes the divider's slow square wave (slow_clk) as a level signal in the clk_in domain and turns each rising edge into a one-cycle tick.
- Counts failed code entries. After MAX_ATTEMPTS consecutive failures it locks input out for LOCKOUT_TICKS slow ticks, then re-arms.
- Drives a lockout flag, a remaining-time count for display, and a blink bit for the status LED.

Parameters:
- MAX_ATTEMPTS, 3: consecutive failures that trigger lockout; must be ≥1.
- LOCKOUT_TICKS, 50: slow ticks per lockout (10 s with the 0.2 s divider period); must be ≥1.
- ATT_W, 2: width of attempts; must hold MAX_ATTEMPTS.
- CNT_W, 6: width of ticks_left; must hold LOCKOUT_TICKS.

Ports:
- clk_in, input, 1: system clock; the only clock.
- rst, input, 1: synchronous, active-high reset.
- slow_clk, input, 1: divider output, treated as data and never used as a clock.
- fail_pulse, input, 1: one-cycle pulse on a wrong code.
- success_pulse, input, 1: one-cycle pulse on a correct code.
- locked_out, output, 1: high while in LOCKOUT.
- attempts, output, ATT_W: consecutive failures so far.
- ticks_left, output, CNT_W: remaining lockout ticks; 0 when armed.
- blink, output, 1: toggles on each tick during lockout; 0 otherwise.
- lockout_done, output, 1: one-cycle pulse when lockout expires.

Behaviour:
- Reset, applied at the clk_in edge when rst=1:
  - state=ARMED, attempts=0, ticks_left=0, locked_out=0, blink=0, lockout_done=0.
  - Synchronizer flops s1, s2 and history flop s3 all cleared.
  - rst mid-lockout aborts the lockout immediately, with no lockout_done pulse.
- Tick generation:
  - s1<=slow_clk, s2<=s1, s3<=s2; tick = s2 & ~s3 (internal).
  - If slow_clk is first sampled high at edge k, tick is high between edges k+1 and k+2 and acts at edge k+2.
  - Exactly one tick per slow_clk rising edge. No tick on falling edges.
  - If slow_clk is high when reset releases, one tick follows. This is harmless in ARMED and is accepted behaviour.
- All outputs are registered. Two states, ARMED and LOCKOUT.
- ARMED:
  - success_pulse: attempts<=0. When asserted together with fail_pulse, success wins and the fail is dropped.
  - fail_pulse only, with attempts+1 < MAX_ATTEMPTS: attempts<=attempts+1.
  - fail_pulse only, with attempts+1 == MAX_ATTEMPTS: next state LOCKOUT, attempts<=MAX_ATTEMPTS, ticks_left<=LOCKOUT_TICKS, locked_out<=1, blink<=0. Outputs update at that same edge (latency 1 cycle from the pulse).
  - Ticks are ignored.
- LOCKOUT:
  - fail_pulse and success_pulse are ignored; attempts and ticks_left are unaffected.
  - tick with ticks_left>1: ticks_left<=ticks_left-1, blink<=~blink.
  - tick with ticks_left==1: next state ARMED, ticks_left<=0, attempts<=0, locked_out<=0, blink<=0, lockout_done<=1 for exactly one cycle.
  - A fail_pulse in the same cycle as the expiring tick is ignored; the lock re-arms clean.
- lockout_done is 0 in every cycle other than the expiry cycle above.
- Width rules:
  - ticks_left never wraps below 0.
  - attempts never exceeds MAX_ATTEMPTS.
  - Constants are truncated to ATT_W/CNT_W. An elaboration check flags parameters that do not fit.

Decomposition:
- Package lock_pkg holds:
  - the state enum {ARMED, LOCKOUT};
  - default MAX_ATTEMPTS and LOCKOUT_TICKS;
  - the shared tick-period constant, so the divider toggle value and LOCKOUT_TICKS are derived together.
- One sub-module, edge_tick: s1/s2/s3 synchronizer plus rising-edge detect. Ports: clk_in, rst, level_in, tick_out. It is reusable for keypad inputs.
- The FSM, counters and output registers stay in lockout_timer.

Test Plan:
All scenarios use MAX_ATTEMPTS=3 and LOCKOUT_TICKS=4. The bench drives slow_clk with 20 cycles high / 20 cycles low.
1. Reset with slow_clk=0 → all outputs 0. Hold 100 cycles with no pulses → state stays ARMED and ticks produce no output change.
2. fail, fail, success, then fail → attempts reads 1, 2, 0, 1; locked_out stays 0.
3. Three fail_pulses → at the edge after the third: locked_out=1, attempts=3, ticks_left=4, blink=0.
   - Each slow_clk rising edge then gives ticks_left 3, 2, 1 with blink 1, 0, 1, each change 2 cycles after slow_clk is sampled high.
   - The 4th tick gives locked_out=0, ticks_left=0, attempts=0, and lockout_done high for exactly 1 cycle.
4. During lockout, inject fail_pulse and success_pulse (including both together) → attempts stays 3 and ticks_left is unchanged. In ARMED with attempts=2, both pulses together → attempts=0, no lockout.
5. Assert rst while ticks_left=2 → next edge shows all outputs 0 and lockout_done never pulses. Three fails afterwards → lockout with ticks_left=4.
6. fail_pulse coincident with the expiring tick → ARMED with attempts=0 and lockout_done=1.
